march_controller: RTL and testbench

Sequencer for the memory BIST datapath that drives the up/down address generator and the memory under test through a March C- algorithm. It issues generator reset/preset/enable/direction controls and memory read/write strobes, then compares read data against expected backgrounds. It records pass/fail status, the first failing address and element, and a saturating error count. It sits between the BIST top-level start/done handshake and the address generator plus memory.

---
 rtl/march_controller.sv | 182 ++++++++++++++++++
 tb/tb_march_controller.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/march_controller.sv
// rtl/march_controller.sv - March C- BIST sequencer: drives address generator and memory, compares reads, records failures
module march_controller #(
    parameter int ad_w = 4,
    parameter int d_w  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [ad_w-1:0] address,
    input  logic [d_w-1:0]  rdata,
    output logic            ag_reset,
    output logic            ag_preset,
    output logic            ag_en,
    output logic            ag_up_down,
    output logic            we,
    output logic            re,
    output logic [d_w-1:0]  wdata,
    output logic            busy,
    output logic            done,
    output logic            fail,
    output logic [ad_w-1:0] fail_addr,
    output logic [2:0]      fail_elem,
    output logic [7:0]      err_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_OP, S_FLUSH, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [2:0]      e_q, e_d;
    logic            o_q, o_d;
    logic            cmp_valid_q, cmp_valid_d;
    logic            cmp_exp_q, cmp_exp_d;
    logic [ad_w-1:0] cmp_addr_q, cmp_addr_d;
    logic [2:0]      cmp_elem_q, cmp_elem_d;
    logic            fail_q, fail_d;
    logic [ad_w-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]      fail_elem_q, fail_elem_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic elem_up, two_op, op_is_read, op_bg, last_op, terminal, mismatch;

    // Element table: E0 w0 | E1 r0,w1 | E2 r1,w0 | E3 r0,w1 (down) | E4 r1,w0 (down) | E5 r0
    always_comb begin
        elem_up    = !(e_q == 3'd3 || e_q == 3'd4);
        two_op     = (e_q != 3'd0) && (e_q != 3'd5);
        op_is_read = two_op ? !o_q : (e_q == 3'd5);
        op_bg      = 1'b0;
        if (two_op) begin
            op_bg = o_q ? (e_q == 3'd1 || e_q == 3'd3) : (e_q == 3'd2 || e_q == 3'd4);
        end
        last_op    = two_op ? o_q : 1'b1;
        terminal   = elem_up ? (&address) : (address == '0);
        mismatch   = cmp_valid_q && (rdata != {d_w{cmp_exp_q}});
    end

    always_comb begin
        ag_reset   = 1'b0;
        ag_preset  = 1'b0;
        ag_en      = 1'b0;
        ag_up_down = 1'b0;
        we         = 1'b0;
        re         = 1'b0;
        wdata      = '0;
        if (state_q == S_SETUP) begin
            ag_reset  = elem_up;
            ag_preset = !elem_up;
        end else if (state_q == S_OP) begin
            re         = op_is_read;
            we         = !op_is_read;
            wdata      = {d_w{op_bg}};
            ag_up_down = elem_up;
            ag_en      = last_op && !terminal;
        end
    end

    always_comb begin
        state_d     = state_q;
        e_d         = e_q;
        o_d         = o_q;
        cmp_valid_d = 1'b0;
        cmp_exp_d   = cmp_exp_q;
        cmp_addr_d  = cmp_addr_q;
        cmp_elem_d  = cmp_elem_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        err_cnt_d   = err_cnt_q;

        // The read issued last cycle is judged now; only the first failure is localised
        if (mismatch) begin
            fail_d    = 1'b1;
            err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
            if (!fail_q) begin
                fail_addr_d = cmp_addr_q;
                fail_elem_d = cmp_elem_q;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_elem_d = '0;
                    err_cnt_d   = '0;
                    e_d         = 3'd0;
                    state_d     = S_SETUP;
                end
            end
            S_SETUP: begin
                o_d     = 1'b0;
                state_d = S_OP;
            end
            S_OP: begin
                if (op_is_read) begin
                    cmp_valid_d = 1'b1;
                    cmp_exp_d   = op_bg;
                    cmp_addr_d  = address;
                    cmp_elem_d  = e_q;
                end
                if (!last_op) begin
                    o_d = 1'b1;
                end else if (!terminal) begin
                    o_d = 1'b0;
                end else if (e_q == 3'd5) begin
                    state_d = S_FLUSH;
                end else begin
                    e_d     = e_q + 3'd1;
                    state_d = S_SETUP;
                end
            end
            S_FLUSH: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_SETUP) || (state_d == S_OP) || (state_d == S_FLUSH);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            e_q         <= '0;
            o_q         <= 1'b0;
            cmp_valid_q <= 1'b0;
            cmp_exp_q   <= 1'b0;
            cmp_addr_q  <= '0;
            cmp_elem_q  <= '0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            err_cnt_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            e_q         <= e_d;
            o_q         <= o_d;
            cmp_valid_q <= cmp_valid_d;
            cmp_exp_q   <= cmp_exp_d;
            cmp_addr_q  <= cmp_addr_d;
            cmp_elem_q  <= cmp_elem_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
            err_cnt_q   <= err_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;
    assign fail_elem = fail_elem_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_march_controller.sv
// tb/tb_march_controller.sv - scoreboard bench for march_controller with fault-injecting memory models
module tb_march_controller;

    typedef struct packed {
        int start_cyc;
        int done_cyc;
        int f;
        int fa;
        int fe;
        int ec;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   mode = 0;

    logic       reset1, start1;
    logic [3:0] addr1 = '0;
    logic [7:0] rdata1 = '0;
    logic       ag_reset1, ag_preset1, ag_en1, ag_ud1, we1, re1, busy1, done1, fail1;
    logic [7:0] wdata1, err_cnt1;
    logic [3:0] fail_addr1;
    logic [2:0] fail_elem1;
    logic [7:0] mem1 [16];

    logic       reset2, start2;
    logic [5:0] addr2 = '0;
    logic [7:0] rdata2 = '0;
    logic       ag_reset2, ag_preset2, ag_en2, ag_ud2, we2, re2, busy2, done2, fail2;
    logic [7:0] wdata2, err_cnt2;
    logic [5:0] fail_addr2;
    logic [2:0] fail_elem2;
    logic [7:0] mem2 [64];

    exp_t sb_q[$];
    exp_t sb2_q[$];
    exp_t mon_r;
    logic rst_s = 1'b0;
    logic busy1_prev = 1'b0, busy2_prev = 1'b0;
    int   re_n, we_n, en_n, e_b, e3_first, e3_last, updn_bad, preset_ok;
    int   err2_prev = 0, wrap2 = 0;

    march_controller #(.ad_w(4), .d_w(8)) dut (
        .clk(clk), .reset(reset1), .start(start1), .address(addr1), .rdata(rdata1),
        .ag_reset(ag_reset1), .ag_preset(ag_preset1), .ag_en(ag_en1), .ag_up_down(ag_ud1),
        .we(we1), .re(re1), .wdata(wdata1), .busy(busy1), .done(done1), .fail(fail1),
        .fail_addr(fail_addr1), .fail_elem(fail_elem1), .err_cnt(err_cnt1)
    );

    march_controller #(.ad_w(6), .d_w(8)) dut_sat (
        .clk(clk), .reset(reset2), .start(start2), .address(addr2), .rdata(rdata2),
        .ag_reset(ag_reset2), .ag_preset(ag_preset2), .ag_en(ag_en2), .ag_up_down(ag_ud2),
        .we(we2), .re(re2), .wdata(wdata2), .busy(busy2), .done(done2), .fail(fail2),
        .fail_addr(fail_addr2), .fail_elem(fail_elem2), .err_cnt(err_cnt2)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [7:0] faulty(input logic [7:0] v, input logic [3:0] a);
        logic [7:0] r;
        r = v;
        case (mode)
            1: if (a == 4'd5) r[0] = 1'b0;
            2: if (a == 4'd0) r[7] = 1'b1;
            3: r = 8'hFF;
            4: r = ~v;
            default: r = v;
        endcase
        return r;
    endfunction

    // Address generator and memory models for both instances
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_s <= reset1;
        if (ag_reset1) addr1 <= '0;
        else if (ag_preset1) addr1 <= '1;
        else if (ag_en1) addr1 <= ag_ud1 ? addr1 + 4'd1 : addr1 - 4'd1;
        if (we1) mem1[addr1] <= wdata1;
        if (re1) rdata1 <= faulty(mem1[addr1], addr1);
        if (ag_reset2) addr2 <= '0;
        else if (ag_preset2) addr2 <= '1;
        else if (ag_en2) addr2 <= ag_ud2 ? addr2 + 6'd1 : addr2 - 6'd1;
        if (we2) mem2[addr2] <= wdata2;
        if (re2) rdata2 <= ~mem2[addr2];
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: all comparisons happen here, away from the active edge
    always @(negedge clk) begin
        if (rst_s) begin
            chk("reset_outputs", int'({busy1, done1, fail1, fail_addr1, fail_elem1, err_cnt1,
                ag_reset1, ag_preset1, ag_en1, ag_ud1, we1, re1, wdata1}), 0);
        end
        if (busy1 && !busy1_prev) begin
            re_n = 0; we_n = 0; en_n = 0; e_b = -1;
            e3_first = -1; e3_last = -1; updn_bad = 0; preset_ok = 0;
        end
        if (ag_reset1 || ag_preset1) begin
            e_b++;
            if (e_b == 3) preset_ok = int'(ag_preset1 && !ag_reset1);
        end
        if (re1) begin
            re_n++;
            if (e_b == 3) begin
                if (e3_first < 0) e3_first = int'(addr1);
                e3_last = int'(addr1);
            end
        end
        if (we1) we_n++;
        if (ag_en1) en_n++;
        if (e_b == 3 && (re1 || we1) && ag_ud1) updn_bad = 1;
        busy1_prev = busy1;

        if (sb_q.size() != 0 && cyc == sb_q[0].start_cyc) chk("busy_at_start", int'(busy1), 1);
        if (done1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_r = sb_q.pop_front();
                chk("done_cycle", cyc, mon_r.done_cyc);
                chk("busy_in_done", int'(busy1), 0);
                chk("fail", int'(fail1), mon_r.f);
                chk("fail_addr", int'(fail_addr1), mon_r.fa);
                chk("fail_elem", int'(fail_elem1), mon_r.fe);
                chk("err_cnt", int'(err_cnt1), mon_r.ec);
                chk("re_count", re_n, 80);
                chk("we_count", we_n, 80);
                chk("ag_en_count", en_n, 90);
                chk("e3_preset", preset_ok, 1);
                chk("e3_first_read_addr", e3_first, 15);
                chk("e3_last_read_addr", e3_last, 0);
                chk("e3_up_down_high", updn_bad, 0);
            end
        end else if (sb_q.size() != 0 && cyc > sb_q[0].done_cyc) begin
            chk("done_timeout", cyc, sb_q[0].done_cyc);
            void'(sb_q.pop_front());
        end

        if (busy2 && busy2_prev && int'(err_cnt2) < err2_prev) wrap2 = 1;
        err2_prev  = int'(err_cnt2);
        busy2_prev = busy2;
        if (done2) begin
            if (sb2_q.size() == 0) begin
                chk("sat_unexpected_done", 1, 0);
            end else begin
                mon_r = sb2_q.pop_front();
                chk("sat_done_cycle", cyc, mon_r.done_cyc);
                chk("sat_fail", int'(fail2), mon_r.f);
                chk("sat_fail_addr", int'(fail_addr2), mon_r.fa);
                chk("sat_fail_elem", int'(fail_elem2), mon_r.fe);
                chk("sat_err_cnt", int'(err_cnt2), mon_r.ec);
                chk("sat_wrapped", wrap2, 0);
            end
        end else if (sb2_q.size() != 0 && cyc > sb2_q[0].done_cyc) begin
            chk("sat_done_timeout", cyc, sb2_q[0].done_cyc);
            void'(sb2_q.pop_front());
        end
    end

    task automatic pulse_start1();
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
    endtask

    task automatic push_exp(input int m);
        exp_t r;
        r.start_cyc = cyc;
        r.done_cyc  = cyc + 167;
        case (m)
            1:       begin r.f = 1; r.fa = 5; r.fe = 2; r.ec = 2;  end
            2:       begin r.f = 1; r.fa = 0; r.fe = 1; r.ec = 3;  end
            3:       begin r.f = 1; r.fa = 0; r.fe = 1; r.ec = 48; end
            4:       begin r.f = 1; r.fa = 0; r.fe = 1; r.ec = 80; end
            default: begin r.f = 0; r.fa = 0; r.fe = 0; r.ec = 0;  end
        endcase
        sb_q.push_back(r);
    endtask

    task automatic run(input int m, input bit extra);
        mode = m;
        pulse_start1();
        push_exp(m);
        if (extra) begin
            repeat (20) @(posedge clk);
            pulse_start1();
            repeat (70) @(posedge clk);
            pulse_start1();
        end
        for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        exp_t r2;
        reset1 = 1'b1; reset2 = 1'b1; start1 = 1'b0; start2 = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset1 = 1'b0; reset2 = 1'b0;

        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        r2.start_cyc = cyc; r2.done_cyc = cyc + 647;
        r2.f = 1; r2.fa = 0; r2.fe = 1; r2.ec = 255;
        sb2_q.push_back(r2);

        run(0, 1'b0);
        run(1, 1'b0);
        run(2, 1'b0);
        run(3, 1'b0);
        run(4, 1'b1);

        // Abort in E2 with failure status already set, with start held high alongside reset
        mode = 4;
        pulse_start1();
        push_exp(4);
        repeat (60) @(posedge clk);
        #1 reset1 = 1'b1; start1 = 1'b1;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 reset1 = 1'b0; start1 = 1'b0;
        repeat (3) @(posedge clk);

        run(0, 1'b0);

        for (int i = 0; i < 1500 && sb2_q.size() != 0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
